// File: rtl/ascii_digit_buffer_pkg.sv
// ascii_digit_buffer_pkg
// Shared constants, FSM state type and ASCII-to-display-code helpers for the
// ASCII digit buffer that feeds the 3-digit scroller.
package ascii_digit_buffer_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_SP   = 8'h20;

  // Codes per scroller read burst (one full 3-digit group)
  localparam int BURST_LEN = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Digits map to 0-9; every other non-delimiter byte shows as blank.
  function automatic logic [3:0] ascii_to_code(input logic [7:0] b);
    logic [7:0] diff;
    diff = b - ASCII_0;
    if ((b >= ASCII_0) && (b <= ASCII_9)) begin
      ascii_to_code = diff[3:0];
    end else begin
      ascii_to_code = BLANK_CODE;
    end
  endfunction

  function automatic logic is_delim(input logic [7:0] b);
    is_delim = (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/ascii_digit_buffer_if.sv
// ascii_digit_buffer_if
// Bundles the UART byte input and the scroller-facing outputs.
//   rx_data/rx_valid : byte strobe from the UART receiver
//   oDEC/oRD         : display code and read strobe to the scroller
//   oOVF             : sticky drop flag
//   oLEVEL           : FIFO occupancy, $clog2(DEPTH)+1 bits
// master = byte source / observer, slave = the buffer itself.
interface ascii_digit_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [3:0]    oDEC;
  logic          oRD;
  logic          oOVF;
  logic [LW-1:0] oLEVEL;

  modport master (
    output rx_data, rx_valid,
    input  oDEC, oRD, oOVF, oLEVEL
  );

  modport slave (
    input  rx_data, rx_valid,
    output oDEC, oRD, oOVF, oLEVEL
  );
endinterface

// File: rtl/ascii_digit_buffer_sync_fifo_4b.sv
// sync_fifo_4b
// Single-clock circular FIFO of 4-bit codes.
//   clk, rst     : clock, asynchronous active-low reset
//   push, wdata  : write strobe and data (caller never pushes when full)
//   pop, rdata   : read strobe; rdata shows the head entry combinationally
//   level, full  : occupancy ($clog2(DEPTH)+1 bits) and level == DEPTH
module sync_fifo_4b #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [3:0]                 wdata,
  input  logic                       pop,
  output logic [3:0]                 rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [3:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = (level_r == LW'(DEPTH));
endmodule

// File: rtl/ascii_digit_buffer.sv
// ascii_digit_buffer
// Converts UART ASCII bytes to 4-bit display codes, groups them in threes
// (padding short groups with blanks on CR/LF) and replays each group to the
// scroller as a 3-cycle read burst, oDEC lagging oRD by one cycle, with at
// least GAP_CYCLES idle cycles between bursts.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of ascii_digit_buffer_if (byte in, scroller out)
module ascii_digit_buffer
  import ascii_digit_buffer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst,
  ascii_digit_buffer_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        state_r, state_nxt_s;
  logic [1:0]    burst_cnt_r, burst_cnt_nxt_s;
  logic [GW-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic [1:0]    pad_cnt_r, pad_cnt_nxt_s;
  logic [1:0]    wr_phase_r, wr_phase_nxt_s;
  logic          rd_r, rd_nxt_s;
  logic [3:0]    dec_r;
  logic          ovf_r, ovf_set_s;
  logic          wr_req_s, drop_s, push_s, pop_s, full_s;
  logic [3:0]    wr_code_s, rdata_s;
  logic [LW-1:0] level_s;

  sync_fifo_4b #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (wr_code_s),
    .pop   (pop_s),
    .rdata (rdata_s),
    .level (level_s),
    .full  (full_s)
  );

  // Write side: pending pad blanks take priority over (and drop) new bytes.
  always_comb begin
    wr_req_s      = 1'b0;
    wr_code_s     = BLANK_CODE;
    pad_cnt_nxt_s = pad_cnt_r;
    drop_s        = 1'b0;
    if (pad_cnt_r != 2'd0) begin
      wr_req_s      = 1'b1;
      pad_cnt_nxt_s = pad_cnt_r - 2'd1;
      drop_s        = bus.rx_valid;
    end else if (bus.rx_valid) begin
      if (is_delim(bus.rx_data)) begin
        // Pad the partial group up to three; a delimiter on a boundary is a no-op.
        if (wr_phase_r != 2'd0) begin
          pad_cnt_nxt_s = 2'(BURST_LEN) - wr_phase_r;
        end else begin
          pad_cnt_nxt_s = 2'd0;
        end
      end else begin
        wr_req_s  = 1'b1;
        wr_code_s = ascii_to_code(bus.rx_data);
      end
    end else begin
      wr_req_s = 1'b0;
    end
    // A refused write leaves the group phase where it was.
    push_s    = wr_req_s && !full_s;
    ovf_set_s = drop_s || (wr_req_s && full_s);
    if (push_s) begin
      wr_phase_nxt_s = (wr_phase_r == 2'(BURST_LEN - 1)) ? 2'd0 : wr_phase_r + 2'd1;
    end else begin
      wr_phase_nxt_s = wr_phase_r;
    end
  end

  // Read-side FSM: burst of three pops, then a guaranteed idle gap.
  always_comb begin
    state_nxt_s     = state_r;
    burst_cnt_nxt_s = burst_cnt_r;
    gap_cnt_nxt_s   = gap_cnt_r;
    pop_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if ((level_s >= LW'(BURST_LEN)) && (gap_cnt_r == {GW{1'b0}})) begin
          state_nxt_s     = BURST;
          burst_cnt_nxt_s = 2'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        pop_s = 1'b1;
        if (burst_cnt_r == 2'(BURST_LEN - 1)) begin
          state_nxt_s     = GAP;
          burst_cnt_nxt_s = 2'd0;
          gap_cnt_nxt_s   = GW'(GAP_CYCLES);
        end else begin
          burst_cnt_nxt_s = burst_cnt_r + 2'd1;
        end
      end
      GAP: begin
        if (gap_cnt_r == {GW{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r - GW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // oRD is the registered image of "in BURST next cycle".
    rd_nxt_s = (state_nxt_s == BURST);
  end

  // State, counters and registered scroller outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      burst_cnt_r <= 2'd0;
      gap_cnt_r   <= {GW{1'b0}};
      pad_cnt_r   <= 2'd0;
      wr_phase_r  <= 2'd0;
      rd_r        <= 1'b0;
      dec_r       <= BLANK_CODE;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
      gap_cnt_r   <= gap_cnt_nxt_s;
      pad_cnt_r   <= pad_cnt_nxt_s;
      wr_phase_r  <= wr_phase_nxt_s;
      rd_r        <= rd_nxt_s;
      ovf_r       <= ovf_r | ovf_set_s;
      // The popped entry appears one edge after its RD cycle.
      if (pop_s) begin
        dec_r <= rdata_s;
      end
    end
  end

  assign bus.oRD    = rd_r;
  assign bus.oDEC   = dec_r;
  assign bus.oOVF   = ovf_r;
  assign bus.oLEVEL = level_s;
endmodule

// File: tb/tb_ascii_digit_buffer.sv
// tb_ascii_digit_buffer
// Directed self-checking bench for ascii_digit_buffer (DEPTH=8, GAP_CYCLES=16).
module tb_ascii_digit_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ascii_digit_buffer_if #(.DEPTH(8)) bus ();
  ascii_digit_buffer #(.DEPTH(8), .GAP_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] got_q [$];
  int min_gap;
  int bad_len;
  int w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic quiet();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b);
    quiet();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for oRD, then checks the 3-high RD window and the lagging codes.
  task automatic burst(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                       input logic [3:0] e2, input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.oRD && waited < budget);
    if (!bus.oRD) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check({tag, "_d0"}, bus.oDEC, e0);
      check({tag, "_rd2"}, bus.oRD, 32'd1);
      @(negedge clk);
      check({tag, "_d1"}, bus.oDEC, e1);
      check({tag, "_rd3"}, bus.oRD, 32'd1);
      @(negedge clk);
      check({tag, "_d2"}, bus.oDEC, e2);
      check({tag, "_rd4"}, bus.oRD, 32'd0);
    end
  endtask

  // Records delivered codes, RD high lengths and low gaps for nb bursts.
  task automatic collect(input int nb, input int budget);
    int hi, lo, falls, cyc;
    logic prev;
    hi = 0; lo = 0; falls = 0; cyc = 0; prev = 1'b0;
    min_gap = 1000; bad_len = 0;
    while (falls < nb && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (prev) got_q.push_back(bus.oDEC);
      if (bus.oRD) begin
        if (!prev && falls > 0 && lo < min_gap) min_gap = lo;
        hi++;
      end else begin
        if (prev) begin
          falls++;
          if (hi != 3) bad_len++;
          hi = 0;
          lo = 0;
        end
        lo++;
      end
      prev = bus.oRD;
    end
    check("collect_bursts", falls, nb);
  endtask

  initial begin
    logic [7:0] digs [12];
    logic [3:0] exp9 [9];
    digs = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
             8'h37, 8'h38, 8'h39, 8'h30, 8'h31, 8'h32};
    exp9 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    idle(2);
    check("rst_rd", bus.oRD, 32'd0);
    check("rst_dec", bus.oDEC, 32'hF);
    check("rst_ovf", bus.oOVF, 32'd0);
    check("rst_lvl", bus.oLEVEL, 32'd0);
    rst = 1'b1;
    idle(2);

    // "123" spaced 20 cycles apart
    send(8'h31); idle(19);
    send(8'h32); idle(19);
    send(8'h33);
    check("123_rd_e0", bus.oRD, 32'd0);
    burst("123", 4'd1, 4'd2, 4'd3, 5, w);
    check("123_lat", w, 32'd1);
    check("123_lvl", bus.oLEVEL, 32'd0);
    idle(25);

    // "4A\r": blank from 'A' plus one pad blank
    drive(8'h34); drive(8'h41); drive(8'h0D); quiet();
    burst("4A", 4'd4, 4'hF, 4'hF, 10, w);
    check("4A_ovf", bus.oOVF, 32'd0);
    check("4A_lvl", bus.oLEVEL, 32'd0);
    idle(25);

    // Delimiter on a group boundary is ignored, then "789"
    send(8'h0D); idle(3);
    check("cr0_lvl", bus.oLEVEL, 32'd0);
    check("cr0_rd", bus.oRD, 32'd0);
    drive(8'h37); drive(8'h38); drive(8'h39); quiet();
    burst("789", 4'd7, 4'd8, 4'd9, 5, w);
    check("789_lat", w, 32'd1);
    idle(25);

    // "5\r" then a byte while padding is pending: dropped
    drive(8'h35); drive(8'h0D); drive(8'h39); quiet();
    burst("5pad", 4'd5, 4'hF, 4'hF, 10, w);
    check("5pad_ovf", bus.oOVF, 32'd1);
    check("5pad_lvl", bus.oLEVEL, 32'd0);
    idle(25);

    // Reset during the second burst cycle
    drive(8'h36); drive(8'h36); drive(8'h36); quiet();
    @(negedge clk);
    check("mid_rd1", bus.oRD, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_rd", bus.oRD, 32'd0);
    check("mid_rst_dec", bus.oDEC, 32'hF);
    check("mid_rst_lvl", bus.oLEVEL, 32'd0);
    check("mid_rst_ovf", bus.oOVF, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    drive(8'h33); drive(8'h32); drive(8'h31); quiet();
    burst("321", 4'd3, 4'd2, 4'd1, 5, w);
    check("321_lat", w, 32'd1);
    idle(25);

    // 12 back-to-back digits: the twelfth hits a full FIFO
    check("full_ovf0", bus.oOVF, 32'd0);
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) drive(digs[i]);
        quiet();
      end
      begin
        collect(3, 300);
      end
    join
    check("full_cnt", got_q.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < got_q.size()) check($sformatf("full_d%0d", i), got_q[i], exp9[i]);
    end
    check("full_gap", (min_gap >= 16) ? 32'd1 : 32'd0, 32'd1);
    check("full_len", bad_len, 32'd0);
    check("full_ovf1", bus.oOVF, 32'd1);
    check("full_lvl", bus.oLEVEL, 32'd2);
    // Phase stayed at 2 despite the drop, so CR pads one blank
    send(8'h0D);
    burst("tail", 4'd0, 4'd1, 4'hF, 40, w);
    check("tail_lvl", bus.oLEVEL, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
